mod_sub_256: RTL and testbench

Word-serial modular subtractor for the ECDSA field datapath. It computes r = (a − b) mod p on 256-bit operands, using a single 16-bit add/subtract slice over multiple cycles. It handles the subtraction side of field arithmetic, next to the existing modular adder chain, and is driven by the point-arithmetic controller through a start/done handshake.

---
 rtl/ecdsa_pkg.sv | 20 ++
 rtl/addsub_16.sv | 18 +
 rtl/mod_sub_256.sv | 99 +++++++++
 tb/tb_mod_sub_256.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ecdsa_pkg.sv
// rtl/ecdsa_pkg.sv - shared constants and state type for the ECDSA field datapath
package ecdsa_pkg;

  localparam int WIDTH = 256;
  localparam int WORD  = 16;
  localparam int NW    = WIDTH / WORD;
  localparam int IW    = $clog2(NW) + 1;

  // Index value one past the last word: the cycle that hands off to DONE
  localparam logic [IW-1:0] I_LAST = IW'(NW - 1);
  localparam logic [IW-1:0] I_END  = IW'(NW);

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    FIX,
    DONE
  } state_e;

endpackage

// File: rtl/addsub_16.sv
// rtl/addsub_16.sv - combinational WORD-bit add/subtract slice
module addsub_16
  import ecdsa_pkg::*;
(
  input  logic [WORD-1:0] x_i,
  input  logic [WORD-1:0] y_i,
  input  logic            cin_i,
  input  logic            sub_i,
  output logic [WORD-1:0] s_o,
  output logic            cout_o
);

  logic [WORD-1:0] y_eff;

  assign y_eff = sub_i ? ~y_i : y_i;
  assign {cout_o, s_o} = {1'b0, x_i} + {1'b0, y_eff} + {{WORD{1'b0}}, cin_i};

endmodule

// File: rtl/mod_sub_256.sv
// rtl/mod_sub_256.sv - word-serial r = (a - b) mod p using one 16-bit slice
module mod_sub_256
  import ecdsa_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r
);

  state_e           state_q;
  logic [IW-1:0]    i_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q, b_q, p_q, r_q;
  logic             busy_q, done_q;

  logic [IW-2:0]    widx;
  logic [IW-1:0]    i_d;
  logic             fix_phase;
  logic [WORD-1:0]  x_w, y_w, sum_w;
  logic             cout_w;

  assign widx      = i_q[IW-2:0];
  assign i_d       = i_q + 1'b1;
  assign fix_phase = (state_q == FIX);

  // SUB: a[i] + ~b[i] + carry ; FIX: r[i] + p[i] + carry
  assign x_w = fix_phase ? r_q[widx*WORD +: WORD] : a_q[widx*WORD +: WORD];
  assign y_w = fix_phase ? p_q[widx*WORD +: WORD] : b_q[widx*WORD +: WORD];

  addsub_16 u_slice (
    .x_i    (x_w),
    .y_i    (y_w),
    .cin_i  (carry_q),
    .sub_i  (~fix_phase),
    .s_o    (sum_w),
    .cout_o (cout_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            p_q     <= p;
            i_q     <= '0;
            carry_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= SUB;
          end else begin
            state_q <= IDLE;
          end
        end
        SUB, FIX: begin
          if (i_q == I_END) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            r_q[widx*WORD +: WORD] <= sum_w;
            // A missing carry out of the top word of a - b means a < b
            if (!fix_phase && i_q == I_LAST && !cout_w) begin
              i_q     <= '0;
              carry_q <= 1'b0;
              state_q <= FIX;
            end else begin
              i_q     <= i_d;
              carry_q <= cout_w;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign r    = r_q;

endmodule

// File: tb/tb_mod_sub_256.sv
// tb/tb_mod_sub_256.sv - randomized self-checking bench for mod_sub_256
module tb_mod_sub_256;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] a, b, p;
  logic         busy, done;
  logic [255:0] r;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  logic [255:0] p25519, pall;

  mod_sub_256 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .p     (p),
    .busy  (busy),
    .done  (done),
    .r     (r)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Field subtraction from its definition: a - b, plus p when that would go negative
  function automatic logic [255:0] ref_sub(input logic [255:0] x, y, m);
    logic [256:0] t;
    if (x >= y) t = {1'b0, x} - {1'b0, y};
    else        t = {1'b0, x} + {1'b0, m} - {1'b0, y};
    return t[255:0];
  endfunction

  function automatic int ref_lat(input logic [255:0] x, y);
    return (x >= y) ? 17 : 33;
  endfunction

  function automatic logic [255:0] rnd_below(input logic [255:0] m);
    logic [255:0] v;
    do begin
      for (int j = 0; j < 8; j++) v[j*32 +: 32] = $urandom;
      v[255] = 1'b0;
      if ($urandom_range(3) == 0) v[255:128] = '0;
    end while (v >= m);
    return v;
  endfunction

  // Waits for done (bounded); k is the index of the first sample after E(k)
  task automatic wait_done(output bit seen, output int k, output int bc, input int inj);
    seen = 0; k = 0; bc = 0;
    while (k < 60 && !seen) begin
      @(negedge clk);
      if (k == inj) begin
        start = 1'b1;
        a = 256'd1;
        b = 256'd2;
        p = 256'd11;
      end else begin
        start = 1'b0;
      end
      if (busy) bc++;
      if (done) seen = 1;
      else k++;
    end
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [255:0] ta, tb_, tp,
                        input logic [255:0] er, input int elat, input int inj);
    bit seen;
    int k, bc, extra;
    @(negedge clk);
    a = ta; b = tb_; p = tp; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~ta; b = ~tb_; p = ~tp;
    wait_done(seen, k, bc, inj);
    check({tag, " done_seen"}, 256'(seen), 256'd1);
    check({tag, " latency"}, 256'(k), 256'(elat));
    check({tag, " busy_cycles"}, 256'(bc), 256'(elat));
    check({tag, " r"}, r, er);
    check({tag, " r_model"}, r, ref_sub(ta, tb_, tp));
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    check({tag, " extra_done"}, 256'(extra), 256'd0);
  endtask

  initial begin
    bit seen;
    int k, bc, snap;
    logic [255:0] ca, cb, na, nb;

    p25519 = (256'd1 << 255) - 256'd19;
    pall   = '1;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; p = '0;
    #1;
    check("reset busy", 256'(busy), 256'd0);
    check("reset done", 256'(done), 256'd0);
    check("reset r", r, 256'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_op("no_borrow", 256'd5, 256'd3, p25519, 256'd2, 17, -1);
    run_op("borrow", 256'd3, 256'd5, 256'd7, 256'd5, 33, -1);
    run_op("xword", 256'h10000, 256'd1, pall, 256'hFFFF, 17, -1);
    run_op("xword_neg", 256'd0, 256'd1, pall, pall - 256'd1, 33, -1);
    run_op("equal_ign", 256'hDEADBEEF, 256'hDEADBEEF, p25519, 256'd0, 17, 5);

    // Reset in the middle of a borrow operation
    @(negedge clk);
    a = 256'd3; b = 256'd5; p = 256'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    snap = done_cnt;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst busy", 256'(busy), 256'd0);
    check("midrst done", 256'(done), 256'd0);
    check("midrst r", r, 256'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("midrst no_done", 256'(done_cnt - snap), 256'd0);
    run_op("after_rst", 256'd100, 256'd250, 256'd1009, 256'd859, 33, -1);

    // Back-to-back random operations, start held through each done cycle
    ca = rnd_below(p25519);
    cb = rnd_below(p25519);
    @(negedge clk);
    a = ca; b = cb; p = p25519; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      wait_done(seen, k, bc, -1);
      check("b2b done_seen", 256'(seen), 256'd1);
      check("b2b latency", 256'(k), 256'(ref_lat(ca, cb)));
      check("b2b r", r, ref_sub(ca, cb, p25519));
      if (n < 999) begin
        na = rnd_below(p25519);
        nb = ($urandom_range(15) == 0) ? na : rnd_below(p25519);
        a = na; b = nb; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("b2b no_gap", 256'(busy), 256'd1);
        ca = na; cb = nb;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
